dma_burst_engine: RTL

//   Parametrised burst DMA between an internal word RAM and the CNN datapath.
//   - READ command: streams LEN words from BASE_ADDR out over a valid/ready port.
//   - WRITE command: accepts LEN words over a valid/ready port and stores them from BASE_ADDR.

---
 rtl/dma_burst_engine.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dma_burst_engine.sv
// Burst DMA between an internal word RAM and a valid/ready stream port.
// A READ burst streams words out of the RAM; a WRITE burst stores incoming words.
module dma_burst_engine #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 15000,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_rw,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [LEN_WIDTH-1:0]  i_length,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int                MEM_AW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_busy;
    logic                  r_done;

    // A word that was never written reads back as its own address, which gives
    // the power-up image "word i = i" without an initialisation sequencer.
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [MEM_DEPTH-1:0]  r_written = '0;

    logic [MEM_AW-1:0]     w_idx;
    logic [ADDR_WIDTH-1:0] w_base_mod;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_wr_fire;

    assign w_idx       = r_addr[MEM_AW-1:0];
    assign w_base_mod  = ADDR_WIDTH'({1'b0, i_base_addr} % DEPTH_W);
    assign w_addr_next = (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
    assign w_rd_word   = r_written[w_idx] ? r_mem[w_idx] : DATA_WIDTH'(r_addr);
    assign w_wr_fire   = !rst && (r_state == WR) && i_in_valid;

    // NOTE: the RAM has no reset branch; contents survive rst, including words
    // already stored by a write burst that the reset aborts.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[w_idx]     <= i_in_data;
            r_written[w_idx] <= 1'b1;
        end
    end

    // NOTE: r_done is defaulted low at the top of the block and only the later
    // non-blocking assignments that enter DONE override it, so it can only pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_addr      <= w_base_mod;
                        r_remaining <= i_length;
                        if (i_length == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= i_rw ? RD : WR;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (r_remaining != '0 && (!r_out_valid || i_out_ready)) begin
                        r_out_data  <= w_rd_word;
                        r_out_valid <= 1'b1;
                        r_addr      <= w_addr_next;
                        r_remaining <= r_remaining - 1'b1;
                    end else if (r_remaining == '0 && r_out_valid && i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                WR: begin
                    if (i_in_valid) begin
                        r_addr      <= w_addr_next;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == LEN_WIDTH'(1)) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // in_ready is the one output decoded straight from state.
    assign o_in_ready  = (r_state == WR);
    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule
